// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : Instruction-decode stage of a 5-stage MIPS-like pipeline.
//            Decodes the IF/ID instruction, reads the 32x32 register file,
//            detects load-use hazards, and loads the ID/EX pipeline register.
// Ports    : clk_i, rst_i            - clock, synchronous active-high reset
//            IFID_pc_i, IFID_ir_i    - instruction and its PC from IF/ID
//            MEM_do_branch_i         - taken branch in MEM, flush ID/EX
//            WB_we_i/waddr_i/wdata_i - register-file write port
//            ID_stall_o              - hold request to IF (combinational)
//            IDEX_*                  - registered operands and control bits
// Config   : `define ID_BYPASS_EN to make a same-cycle WB write visible to
//            the decode read (write-through); otherwise reads return the
//            pre-write contents.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] IFID_pc_i,
    input  logic [31:0] IFID_ir_i,
    input  logic        MEM_do_branch_i,
    input  logic        WB_we_i,
    input  logic [4:0]  WB_waddr_i,
    input  logic [31:0] WB_wdata_i,
    output logic        ID_stall_o,
    output logic [31:0] IDEX_pc_o,
    output logic [31:0] IDEX_rs_val_o,
    output logic [31:0] IDEX_rt_val_o,
    output logic [31:0] IDEX_imm_o,
    output logic [4:0]  IDEX_dest_o,
    output logic [2:0]  IDEX_alu_op_o,
    output logic        IDEX_reg_we_o,
    output logic        IDEX_mem_read_o,
    output logic        IDEX_mem_write_o,
    output logic        IDEX_branch_o,
    output logic        IDEX_use_imm_o,
    output logic        IDEX_valid_o
);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b100;

    // ---------------- instruction fields ----------------
    logic [5:0] w_opcode, w_funct;
    logic [4:0] w_rs, w_rt, w_rd;
    assign w_opcode = IFID_ir_i[31:26];
    assign w_rs     = IFID_ir_i[25:21];
    assign w_rt     = IFID_ir_i[20:16];
    assign w_rd     = IFID_ir_i[15:11];
    assign w_funct  = IFID_ir_i[5:0];

    // ---------------- decode ----------------
    logic       w_dec_valid, w_dec_reads_rt, w_dec_reg_we;
    logic       w_dec_mem_read, w_dec_mem_write, w_dec_branch, w_dec_use_imm;
    logic [2:0] w_dec_alu_op;
    logic [4:0] w_dec_dest;

    always_comb begin
        w_dec_valid     = 1'b0;
        w_dec_reads_rt  = 1'b0;
        w_dec_reg_we    = 1'b0;
        w_dec_mem_read  = 1'b0;
        w_dec_mem_write = 1'b0;
        w_dec_branch    = 1'b0;
        w_dec_use_imm   = 1'b0;
        w_dec_alu_op    = c_alu_add;
        w_dec_dest      = 5'd0;
        case (w_opcode)
            c_op_rtype: begin
                w_dec_valid = 1'b1;
                case (w_funct)
                    6'h20:   w_dec_alu_op = c_alu_add;
                    6'h22:   w_dec_alu_op = c_alu_sub;
                    6'h24:   w_dec_alu_op = c_alu_and;
                    6'h25:   w_dec_alu_op = c_alu_or;
                    6'h2A:   w_dec_alu_op = c_alu_slt;
                    default: w_dec_valid  = 1'b0;
                endcase
                // Unknown funct (including ir == 0) stays a bubble.
                if (w_dec_valid) begin
                    w_dec_reads_rt = 1'b1;
                    w_dec_reg_we   = 1'b1;
                    w_dec_dest     = w_rd;
                end else begin
                    w_dec_alu_op   = c_alu_add;
                end
            end
            c_op_addi: begin
                w_dec_valid   = 1'b1;
                w_dec_reg_we  = 1'b1;
                w_dec_use_imm = 1'b1;
                w_dec_dest    = w_rt;
            end
            c_op_lw: begin
                w_dec_valid    = 1'b1;
                w_dec_reg_we   = 1'b1;
                w_dec_mem_read = 1'b1;
                w_dec_use_imm  = 1'b1;
                w_dec_dest     = w_rt;
            end
            c_op_sw: begin
                w_dec_valid     = 1'b1;
                w_dec_reads_rt  = 1'b1;
                w_dec_mem_write = 1'b1;
                w_dec_use_imm   = 1'b1;
            end
            c_op_beq: begin
                w_dec_valid    = 1'b1;
                w_dec_reads_rt = 1'b1;
                w_dec_branch   = 1'b1;
                w_dec_alu_op   = c_alu_sub;
            end
            default: ;
        endcase
    end

    // ---------------- register file ----------------
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] w_rs_val, w_rt_val;

    always_comb begin
        regs_d = regs_q;
        if (WB_we_i && (WB_waddr_i != 5'd0)) begin
            regs_d[WB_waddr_i] = WB_wdata_i;
        end
    end

    always_comb begin
        w_rs_val = (w_rs == 5'd0) ? 32'd0 : regs_q[w_rs];
        w_rt_val = (w_rt == 5'd0) ? 32'd0 : regs_q[w_rt];
`ifdef ID_BYPASS_EN
        // Write-through: the WB value wins over the stored copy this cycle.
        if (WB_we_i && (WB_waddr_i != 5'd0) && (WB_waddr_i == w_rs)) w_rs_val = WB_wdata_i;
        if (WB_we_i && (WB_waddr_i != 5'd0) && (WB_waddr_i == w_rt)) w_rt_val = WB_wdata_i;
`endif
    end

    // ---------------- ID/EX pipeline register ----------------
    logic [31:0] idex_pc_q, idex_rs_val_q, idex_rt_val_q, idex_imm_q;
    logic [31:0] idex_pc_d, idex_rs_val_d, idex_rt_val_d, idex_imm_d;
    logic [4:0]  idex_dest_q, idex_dest_d;
    logic [2:0]  idex_alu_op_q, idex_alu_op_d;
    logic        idex_reg_we_q, idex_mem_read_q, idex_mem_write_q;
    logic        idex_branch_q, idex_use_imm_q, idex_valid_q;
    logic        idex_reg_we_d, idex_mem_read_d, idex_mem_write_d;
    logic        idex_branch_d, idex_use_imm_d, idex_valid_d;

    // Load in EX whose destination is a source actually read by this
    // instruction; r0 is never a real dependency.
    logic w_hazard;
    assign w_hazard = idex_valid_q && idex_mem_read_q && (idex_dest_q != 5'd0) &&
                      ((w_dec_valid    && (idex_dest_q == w_rs)) ||
                       (w_dec_reads_rt && (idex_dest_q == w_rt)));

    // A flush kills the instruction anyway, so it suppresses the stall.
    assign ID_stall_o = w_hazard && !MEM_do_branch_i && !rst_i;

    always_comb begin
        idex_pc_d        = 32'd0;
        idex_rs_val_d    = 32'd0;
        idex_rt_val_d    = 32'd0;
        idex_imm_d       = 32'd0;
        idex_dest_d      = 5'd0;
        idex_alu_op_d    = c_alu_add;
        idex_reg_we_d    = 1'b0;
        idex_mem_read_d  = 1'b0;
        idex_mem_write_d = 1'b0;
        idex_branch_d    = 1'b0;
        idex_use_imm_d   = 1'b0;
        idex_valid_d     = 1'b0;
        if (w_dec_valid && !MEM_do_branch_i && !w_hazard) begin
            idex_pc_d        = IFID_pc_i;
            idex_rs_val_d    = w_rs_val;
            idex_rt_val_d    = w_rt_val;
            idex_imm_d       = {{16{IFID_ir_i[15]}}, IFID_ir_i[15:0]};
            idex_dest_d      = w_dec_dest;
            idex_alu_op_d    = w_dec_alu_op;
            idex_reg_we_d    = w_dec_reg_we;
            idex_mem_read_d  = w_dec_mem_read;
            idex_mem_write_d = w_dec_mem_write;
            idex_branch_d    = w_dec_branch;
            idex_use_imm_d   = w_dec_use_imm;
            idex_valid_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q           <= '{default: 32'd0};
            idex_pc_q        <= 32'd0;
            idex_rs_val_q    <= 32'd0;
            idex_rt_val_q    <= 32'd0;
            idex_imm_q       <= 32'd0;
            idex_dest_q      <= 5'd0;
            idex_alu_op_q    <= 3'd0;
            idex_reg_we_q    <= 1'b0;
            idex_mem_read_q  <= 1'b0;
            idex_mem_write_q <= 1'b0;
            idex_branch_q    <= 1'b0;
            idex_use_imm_q   <= 1'b0;
            idex_valid_q     <= 1'b0;
        end else begin
            regs_q           <= regs_d;
            idex_pc_q        <= idex_pc_d;
            idex_rs_val_q    <= idex_rs_val_d;
            idex_rt_val_q    <= idex_rt_val_d;
            idex_imm_q       <= idex_imm_d;
            idex_dest_q      <= idex_dest_d;
            idex_alu_op_q    <= idex_alu_op_d;
            idex_reg_we_q    <= idex_reg_we_d;
            idex_mem_read_q  <= idex_mem_read_d;
            idex_mem_write_q <= idex_mem_write_d;
            idex_branch_q    <= idex_branch_d;
            idex_use_imm_q   <= idex_use_imm_d;
            idex_valid_q     <= idex_valid_d;
        end
    end

    assign IDEX_pc_o        = idex_pc_q;
    assign IDEX_rs_val_o    = idex_rs_val_q;
    assign IDEX_rt_val_o    = idex_rt_val_q;
    assign IDEX_imm_o       = idex_imm_q;
    assign IDEX_dest_o      = idex_dest_q;
    assign IDEX_alu_op_o    = idex_alu_op_q;
    assign IDEX_reg_we_o    = idex_reg_we_q;
    assign IDEX_mem_read_o  = idex_mem_read_q;
    assign IDEX_mem_write_o = idex_mem_write_q;
    assign IDEX_branch_o    = idex_branch_q;
    assign IDEX_use_imm_o   = idex_use_imm_q;
    assign IDEX_valid_o     = idex_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Self-checking bench for id_stage: directed scenarios with
//            literal expectations, then randomized instruction streams
//            compared every cycle against a behavioural pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_i, MEM_do_branch_i, WB_we_i;
    logic [31:0] IFID_pc_i, IFID_ir_i, WB_wdata_i;
    logic [4:0]  WB_waddr_i;
    logic        ID_stall_o;
    logic [31:0] IDEX_pc_o, IDEX_rs_val_o, IDEX_rt_val_o, IDEX_imm_o;
    logic [4:0]  IDEX_dest_o;
    logic [2:0]  IDEX_alu_op_o;
    logic        IDEX_reg_we_o, IDEX_mem_read_o, IDEX_mem_write_o;
    logic        IDEX_branch_o, IDEX_use_imm_o, IDEX_valid_o;

    always #5 clk = ~clk;

    id_stage dut (
        .clk_i(clk), .rst_i(rst_i),
        .IFID_pc_i(IFID_pc_i), .IFID_ir_i(IFID_ir_i),
        .MEM_do_branch_i(MEM_do_branch_i),
        .WB_we_i(WB_we_i), .WB_waddr_i(WB_waddr_i), .WB_wdata_i(WB_wdata_i),
        .ID_stall_o(ID_stall_o),
        .IDEX_pc_o(IDEX_pc_o), .IDEX_rs_val_o(IDEX_rs_val_o),
        .IDEX_rt_val_o(IDEX_rt_val_o), .IDEX_imm_o(IDEX_imm_o),
        .IDEX_dest_o(IDEX_dest_o), .IDEX_alu_op_o(IDEX_alu_op_o),
        .IDEX_reg_we_o(IDEX_reg_we_o), .IDEX_mem_read_o(IDEX_mem_read_o),
        .IDEX_mem_write_o(IDEX_mem_write_o), .IDEX_branch_o(IDEX_branch_o),
        .IDEX_use_imm_o(IDEX_use_imm_o), .IDEX_valid_o(IDEX_valid_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       valid, reads_rt, we, mr, mw, br, ui;
        logic [2:0] alu;
        logic [4:0] dest;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc, rs, rt, imm;
        logic [4:0]  dest;
        logic [2:0]  alu;
        logic        we, mr, mw, br, ui, valid;
    } ex_t;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d = '0;
        case (ir[31:26])
            6'h00: begin
                d.valid = 1'b1;
                case (ir[5:0])
                    6'h20: d.alu = 3'd0;
                    6'h22: d.alu = 3'd1;
                    6'h24: d.alu = 3'd2;
                    6'h25: d.alu = 3'd3;
                    6'h2A: d.alu = 3'd4;
                    default: d = '0;
                endcase
                if (d.valid) begin d.reads_rt = 1'b1; d.we = 1'b1; d.dest = ir[15:11]; end
            end
            6'h08: begin d.valid = 1'b1; d.we = 1'b1; d.ui = 1'b1; d.dest = ir[20:16]; end
            6'h23: begin d.valid = 1'b1; d.we = 1'b1; d.mr = 1'b1; d.ui = 1'b1; d.dest = ir[20:16]; end
            6'h2B: begin d.valid = 1'b1; d.mw = 1'b1; d.ui = 1'b1; d.reads_rt = 1'b1; end
            6'h04: begin d.valid = 1'b1; d.br = 1'b1; d.reads_rt = 1'b1; d.alu = 3'd1; end
            default: d = '0;
        endcase
        return d;
    endfunction

    logic [31:0] m_regs [32];
    ex_t         m_ex;
    bit          m_hold = 1'b0;
    bit          chk_en = 1'b0;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ID_BYPASS_EN
        if (WB_we_i && WB_waddr_i == a) return WB_wdata_i;
`endif
        return m_regs[a];
    endfunction

    function automatic bit m_stall();
        dec_t d;
        if (rst_i || MEM_do_branch_i) return 1'b0;
        if (!(m_ex.valid && m_ex.mr && m_ex.dest != 5'd0)) return 1'b0;
        d = decode(IFID_ir_i);
        return (d.valid && IFID_ir_i[25:21] == m_ex.dest) ||
               (d.reads_rt && IFID_ir_i[20:16] == m_ex.dest);
    endfunction

    always @(posedge clk) begin : model
        dec_t d;
        ex_t  nx;
        bit   st;
        st     = m_stall();
        m_hold = st;
        if (rst_i) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_ex   = '0;
            chk_en = 1'b1;
        end else begin
            d  = decode(IFID_ir_i);
            nx = '0;
            if (d.valid && !MEM_do_branch_i && !st) begin
                nx.pc    = IFID_pc_i;
                nx.rs    = m_read(IFID_ir_i[25:21]);
                nx.rt    = m_read(IFID_ir_i[20:16]);
                nx.imm   = {{16{IFID_ir_i[15]}}, IFID_ir_i[15:0]};
                nx.dest  = d.dest;
                nx.alu   = d.alu;
                nx.we    = d.we;
                nx.mr    = d.mr;
                nx.mw    = d.mw;
                nx.br    = d.br;
                nx.ui    = d.ui;
                nx.valid = 1'b1;
            end
            m_ex = nx;
            if (WB_we_i && WB_waddr_i != 5'd0) m_regs[WB_waddr_i] = WB_wdata_i;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",     {31'd0, ID_stall_o},       {31'd0, m_stall()});
            chk("valid",     {31'd0, IDEX_valid_o},     {31'd0, m_ex.valid});
            chk("reg_we",    {31'd0, IDEX_reg_we_o},    {31'd0, m_ex.we});
            chk("mem_read",  {31'd0, IDEX_mem_read_o},  {31'd0, m_ex.mr});
            chk("mem_write", {31'd0, IDEX_mem_write_o}, {31'd0, m_ex.mw});
            chk("branch",    {31'd0, IDEX_branch_o},    {31'd0, m_ex.br});
            chk("use_imm",   {31'd0, IDEX_use_imm_o},   {31'd0, m_ex.ui});
            chk("dest",      {27'd0, IDEX_dest_o},      {27'd0, m_ex.dest});
            if (m_ex.valid) begin
                chk("alu_op", {29'd0, IDEX_alu_op_o}, {29'd0, m_ex.alu});
                chk("pc",     IDEX_pc_o,     m_ex.pc);
                chk("rs_val", IDEX_rs_val_o, m_ex.rs);
                chk("rt_val", IDEX_rt_val_o, m_ex.rt);
                chk("imm",    IDEX_imm_o,    m_ex.imm);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic [31:0] pc, input logic [31:0] ir, input logic br,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rst);
        IFID_pc_i = pc; IFID_ir_i = ir; MEM_do_branch_i = br;
        WB_we_i = we; WB_waddr_i = wa; WB_wdata_i = wd; rst_i = rst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fn;
        int          k;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        k   = $urandom_range(0, 4);
        fn  = (k == 0) ? 6'h20 : (k == 1) ? 6'h22 : (k == 2) ? 6'h24 : (k == 3) ? 6'h25 : 6'h2A;
        case ($urandom_range(0, 9))
            0, 1:    return {6'h00, rs, rt, rd, 5'd0, fn};
            2:       return {6'h08, rs, rt, imm};
            3, 4:    return {6'h23, rs, rt, imm};
            5:       return {6'h2B, rs, rt, imm};
            6:       return {6'h04, rs, rt, imm};
            7:       return 32'h0000_0000;
            8:       return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            default: return {6'h3F, rs, rt, imm};
        endcase
    endfunction

    localparam logic [31:0] c_add_r3_r1_r2 = 32'h0022_1820;
    localparam logic [31:0] c_lw_r4_8_r1   = 32'h8C24_0008;
    localparam logic [31:0] c_add_r5_r4_r1 = 32'h0081_2820;
    localparam logic [31:0] c_add_r5_r1_r2 = 32'h0022_2820;
    localparam logic [31:0] c_addi_r6_m1   = 32'h2006_FFFF;
    localparam logic [31:0] c_add_r8_r7_r0 = 32'h00E0_4020;
    localparam logic [31:0] c_add_r8_r0_r0 = 32'h0000_4020;

    initial begin
        logic [31:0] pc, ir;
        drv(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(); tick();
        chk("rst_valid", {31'd0, IDEX_valid_o}, 32'd0);
        chk("rst_pc", IDEX_pc_o, 32'd0);
        chk("rst_stall", {31'd0, ID_stall_o}, 32'd0);

        // Write r1=5, r2=7 then ADD r3,r1,r2
        drv(32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b0); tick();
        drv(32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'd7, 1'b0); tick();
        drv(32'h100, c_add_r3_r1_r2, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); tick();
        chk("add_rs", IDEX_rs_val_o, 32'd5);
        chk("add_rt", IDEX_rt_val_o, 32'd7);
        chk("add_dest", {27'd0, IDEX_dest_o}, 32'd3);
        chk("add_alu", {29'd0, IDEX_alu_op_o}, 32'd0);
        chk("add_we", {31'd0, IDEX_reg_we_o}, 32'd1);
        chk("add_valid", {31'd0, IDEX_valid_o}, 32'd1);
        chk("add_pc", IDEX_pc_o, 32'h100);

        // Load-use: LW r4 then ADD r5,r4,r1
        drv(32'h104, c_lw_r4_8_r1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); tick();
        chk("lw_imm", IDEX_imm_o, 32'd8);
        drv(32'h108, c_add_r5_r4_r1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); #1;
        chk("lu_stall", {31'd0, ID_stall_o}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, IDEX_valid_o}, 32'd0);
        chk("lu_stall_end", {31'd0, ID_stall_o}, 32'd0);
        tick();
        chk("lu_issue_valid", {31'd0, IDEX_valid_o}, 32'd1);
        chk("lu_issue_dest", {27'd0, IDEX_dest_o}, 32'd5);

        // LW then independent ADD
        drv(32'h10C, c_lw_r4_8_r1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); tick();
        drv(32'h110, c_add_r5_r1_r2, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); #1;
        chk("nodep_stall", {31'd0, ID_stall_o}, 32'd0);
        tick();
        chk("nodep_valid", {31'd0, IDEX_valid_o}, 32'd1);
        chk("nodep_rt", IDEX_rt_val_o, 32'd7);

        // Flush during ADDI r6,r0,-1
        drv(32'h114, c_addi_r6_m1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0); #1;
        chk("flush_stall", {31'd0, ID_stall_o}, 32'd0);
        tick();
        chk("flush_bubble", {31'd0, IDEX_valid_o}, 32'd0);
        drv(32'h114, c_addi_r6_m1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); tick();
        chk("addi_imm", IDEX_imm_o, 32'hFFFF_FFFF);
        chk("addi_dest", {27'd0, IDEX_dest_o}, 32'd6);

        // Same-cycle WB write of r7 and read of r7
        drv(32'h118, c_add_r8_r7_r0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0); tick();
`ifdef ID_BYPASS_EN
        chk("wb_same_cycle", IDEX_rs_val_o, 32'hDEAD_BEEF);
`else
        chk("wb_same_cycle", IDEX_rs_val_o, 32'd0);
`endif
        drv(32'h118, c_add_r8_r7_r0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); tick();
        chk("wb_next_cycle", IDEX_rs_val_o, 32'hDEAD_BEEF);

        // r0 write ignored, ir=0 bubble
        drv(32'h11C, c_add_r8_r0_r0, 1'b0, 1'b1, 5'd0, 32'd9, 1'b0); tick();
        drv(32'h120, c_add_r8_r0_r0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); tick();
        chk("r0_read", IDEX_rs_val_o, 32'd0);
        drv(32'h124, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); tick();
        chk("zero_ir_valid", {31'd0, IDEX_valid_o}, 32'd0);
        chk("zero_ir_we", {31'd0, IDEX_reg_we_o}, 32'd0);

        // Reset while stalled
        drv(32'h128, c_lw_r4_8_r1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); tick();
        drv(32'h12C, c_add_r5_r4_r1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1); #1;
        chk("rst_stall_forced0", {31'd0, ID_stall_o}, 32'd0);
        tick();
        chk("rst_mid_valid", {31'd0, IDEX_valid_o}, 32'd0);
        chk("rst_mid_mr", {31'd0, IDEX_mem_read_o}, 32'd0);
        chk("rst_mid_pc", IDEX_pc_o, 32'd0);
        drv(32'h12C, c_add_r5_r4_r1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); tick();
        chk("post_rst_valid", {31'd0, IDEX_valid_o}, 32'd1);
        chk("post_rst_rt", IDEX_rt_val_o, 32'd0);

        // Randomized stream
        pc = 32'h1000;
        ir = rand_ir();
        for (int c = 0; c < 800; c++) begin
            if (!m_hold) begin
                pc = pc + 32'd4;
                ir = rand_ir();
            end
            drv(pc, ir, ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 59) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
